axis_spi_slave: RTL

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit words) bridging an external SPI bus to AXI-Stream. Pairs with the team's SPI master for loopback benches and serves as the FPGA-side target when an external controller drives the bus. The block samples SCK, SS_N and MOSI in the aclk domain. Received bytes go out on m_axis; bytes for MISO come from s_axis.

---
 rtl/axis_spi_slave.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axis_spi_slave.sv
// SPI mode-0 slave (MSB first, 8-bit words) bridging an external SPI bus to AXI-Stream.
// SCK/SS_N/MOSI are oversampled in the aclk domain; rx bytes leave on m_axis, tx bytes come from s_axis.
module axis_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       SCK,
    input  logic       SS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_T,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       stat_rx_overflow,
    output logic       stat_tx_underflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEEK  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    logic [1:0] state_q;
    logic [2:0] bit_cnt_q;
    logic       byte_done_q;
    logic       peek_valid_q;
    logic [6:0] tx_sr_q;
    logic [7:0] rx_sr_q;
    logic       rx_done_q;
    logic       miso_q, miso_t_q;
    logic       commit;

    // SS_N synchronizer resets high so a deselected bus does not look like a frame start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;

    // First rise of a byte commits the peeked s_axis word; tready is combinational so the
    // handshake lands on the same edge the shift register loads tdata.
    assign commit        = (state_q == ST_SHIFT) && sck_rise && !ss_rise
                           && !byte_done_q && (bit_cnt_q == 3'd0);
    assign s_axis_tready = commit & peek_valid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q           <= ST_IDLE;
            bit_cnt_q         <= 3'd0;
            byte_done_q       <= 1'b0;
            peek_valid_q      <= 1'b0;
            tx_sr_q           <= 7'd0;
            rx_sr_q           <= 8'd0;
            rx_done_q         <= 1'b0;
            miso_q            <= 1'b0;
            miso_t_q          <= 1'b1;
            stat_tx_underflow <= 1'b0;
            stat_rx_overflow  <= 1'b0;
            m_axis_tdata      <= 8'd0;
            m_axis_tvalid     <= 1'b0;
        end else begin
            rx_done_q         <= 1'b0;
            stat_tx_underflow <= 1'b0;
            stat_rx_overflow  <= 1'b0;

            if (ss_rise) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                miso_t_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ss_fall) state_q <= ST_PEEK;
                    end
                    ST_PEEK: begin
                        peek_valid_q <= s_axis_tvalid;
                        miso_q       <= s_axis_tvalid ? s_axis_tdata[7] : DEFAULT_TX[7];
                        miso_t_q     <= 1'b0;
                        state_q      <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (sck_rise && !byte_done_q) begin
                            rx_sr_q <= {rx_sr_q[6:0], mosi_s};
                            if (bit_cnt_q == 3'd0) begin
                                tx_sr_q           <= peek_valid_q ? s_axis_tdata[6:0] : DEFAULT_TX[6:0];
                                stat_tx_underflow <= ~peek_valid_q;
                            end
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q   <= 3'd0;
                                byte_done_q <= 1'b1;
                                rx_done_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end else if (sck_fall) begin
                            if (byte_done_q) begin
                                byte_done_q <= 1'b0;
                                state_q     <= ST_PEEK;
                            end else if (bit_cnt_q != 3'd0) begin
                                miso_q  <= tx_sr_q[6];
                                tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // A completed byte is delivered even if SS_N rises right after its last edge.
            if (rx_done_q) begin
                if (m_axis_tvalid && !m_axis_tready) begin
                    stat_rx_overflow <= 1'b1;
                end else begin
                    m_axis_tdata  <= rx_sr_q;
                    m_axis_tvalid <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    assign MISO   = miso_q;
    assign MISO_T = miso_t_q;

endmodule
